// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports, clear handshake, RAM side and status.
// slave is the arbiter's view; master is the requester/RAM view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_rw;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req;
    logic              b_rw;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              clr_req;
    logic              clr_done;
    logic              mem_rw;
    logic              mem_clr;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_out_valid;
    logic [1:0]        grant;
    logic              busy;
    logic              timeout_err;

    modport slave (
        input  a_req, a_rw, a_addr, a_wdata, b_req, b_rw, b_addr, b_wdata,
               clr_req, mem_data_out, mem_out_valid,
        output a_ack, a_rdata, b_ack, b_rdata, clr_done, mem_rw, mem_clr,
               mem_address, mem_data_in, grant, busy, timeout_err
    );

    modport master (
        output a_req, a_rw, a_addr, a_wdata, b_req, b_rw, b_addr, b_wdata,
               clr_req, mem_data_out, mem_out_valid,
        input  a_ack, a_rdata, b_ack, b_rdata, clr_done, mem_rw, mem_clr,
               mem_address, mem_data_in, grant, busy, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the single-port data RAM with clear sequencing and a read-timeout watchdog.
// Every output is a register loaded with the value the next state needs.
module mem_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    mem_arbiter_if.slave   bus
);
    localparam logic [3:0] TIMEOUT_C  = 4'(TIMEOUT);
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_A    = 2'b01;
    localparam logic [1:0] GRANT_B    = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR     = 3'd1,
        ISSUE   = 3'd2,
        WAIT_RD = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic              last_b_r, last_b_s;
    logic              rw_r, rw_s;
    logic [1:0]        grant_r, grant_s;
    logic [3:0]        cnt_r, cnt_s, cnt_inc_s;
    logic              mem_rw_r, mem_rw_s;
    logic              mem_clr_r, mem_clr_s;
    logic [ADDR_W-1:0] mem_address_r, mem_address_s;
    logic [DATA_W-1:0] mem_data_in_r, mem_data_in_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic              a_ack_r, a_ack_s;
    logic              b_ack_r, b_ack_s;
    logic              clr_done_r, clr_done_s;
    logic              busy_r, busy_s;
    logic              timeout_err_r, timeout_err_s;
    logic              win_a_s;
    logic              resp_s;

    // Next-state and next-output computation.
    always_comb begin
        state_s       = state_r;
        last_b_s      = last_b_r;
        rw_s          = rw_r;
        grant_s       = grant_r;
        cnt_s         = cnt_r;
        mem_rw_s      = 1'b0;
        mem_clr_s     = 1'b0;
        mem_address_s = mem_address_r;
        mem_data_in_s = mem_data_in_r;
        rdata_s       = rdata_r;
        clr_done_s    = 1'b0;
        timeout_err_s = timeout_err_r;
        resp_s        = 1'b0;
        cnt_inc_s     = cnt_r + 4'd1;
        // A wins when alone, or on a tie when B owned the previous grant.
        win_a_s       = bus.a_req & (~bus.b_req | last_b_r);

        case (state_r)
            IDLE: begin
                if (bus.clr_req) begin
                    state_s   = CLR;
                    mem_clr_s = 1'b1;
                end else if (bus.a_req | bus.b_req) begin
                    state_s  = ISSUE;
                    last_b_s = ~win_a_s;
                    if (win_a_s) begin
                        grant_s       = GRANT_A;
                        rw_s          = bus.a_rw;
                        mem_address_s = bus.a_addr;
                        mem_data_in_s = bus.a_wdata;
                    end else begin
                        grant_s       = GRANT_B;
                        rw_s          = bus.b_rw;
                        mem_address_s = bus.b_addr;
                        mem_data_in_s = bus.b_wdata;
                    end
                    mem_rw_s = rw_s;
                end else begin
                    state_s = IDLE;
                end
            end
            CLR: begin
                state_s       = RESP;
                clr_done_s    = 1'b1;
                timeout_err_s = 1'b0;
            end
            ISSUE: begin
                cnt_s = 4'd0;
                if (rw_r) begin
                    state_s = RESP;
                    resp_s  = 1'b1;
                end else begin
                    state_s = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (bus.mem_out_valid) begin
                    rdata_s = bus.mem_data_out;
                    state_s = RESP;
                    resp_s  = 1'b1;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    timeout_err_s = 1'b1;
                    rdata_s       = {DATA_W{1'b0}};
                    state_s       = RESP;
                    resp_s        = 1'b1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            RESP: begin
                state_s = IDLE;
                grant_s = GRANT_NONE;
            end
            default: begin
                state_s = IDLE;
                grant_s = GRANT_NONE;
            end
        endcase

        a_ack_s = resp_s & (grant_r == GRANT_A);
        b_ack_s = resp_s & (grant_r == GRANT_B);
        busy_s  = (state_s != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            last_b_r      <= 1'b1;
            rw_r          <= 1'b0;
            grant_r       <= GRANT_NONE;
            cnt_r         <= 4'd0;
            mem_rw_r      <= 1'b0;
            mem_clr_r     <= 1'b0;
            mem_address_r <= {ADDR_W{1'b0}};
            mem_data_in_r <= {DATA_W{1'b0}};
            rdata_r       <= {DATA_W{1'b0}};
            a_ack_r       <= 1'b0;
            b_ack_r       <= 1'b0;
            clr_done_r    <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            last_b_r      <= last_b_s;
            rw_r          <= rw_s;
            grant_r       <= grant_s;
            cnt_r         <= cnt_s;
            mem_rw_r      <= mem_rw_s;
            mem_clr_r     <= mem_clr_s;
            mem_address_r <= mem_address_s;
            mem_data_in_r <= mem_data_in_s;
            rdata_r       <= rdata_s;
            a_ack_r       <= a_ack_s;
            b_ack_r       <= b_ack_s;
            clr_done_r    <= clr_done_s;
            busy_r        <= busy_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    // Both ports see the shared read register; it is meaningful only during that port's ack.
    assign bus.a_ack       = a_ack_r;
    assign bus.a_rdata     = rdata_r;
    assign bus.b_ack       = b_ack_r;
    assign bus.b_rdata     = rdata_r;
    assign bus.clr_done    = clr_done_r;
    assign bus.mem_rw      = mem_rw_r;
    assign bus.mem_clr     = mem_clr_r;
    assign bus.mem_address = mem_address_r;
    assign bus.mem_data_in = mem_data_in_r;
    assign bus.grant       = grant_r;
    assign bus.busy        = busy_r;
    assign bus.timeout_err = timeout_err_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model expands each grant into its expected
// per-cycle output schedule, plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 4;

    typedef struct {
        logic          a_ack, b_ack, clr_done, mem_rw, mem_clr, busy, terr;
        logic          wt, ram_valid, chk_rd;
        logic [1:0]    grant;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata, rdata, ram_data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    exp_t          exp_q[$];
    exp_t          cur;
    logic [DW-1:0] ram [0:15];
    logic          m_last_b, m_terr, cur_idle, rand_mode;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            force_k, p_req, p_clr;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t base(input logic bsy);
        exp_t e;
        e.a_ack = 1'b0; e.b_ack = 1'b0; e.clr_done = 1'b0; e.mem_rw = 1'b0; e.mem_clr = 1'b0;
        e.busy = bsy; e.terr = m_terr; e.wt = 1'b0; e.ram_valid = 1'b0; e.chk_rd = 1'b0;
        e.grant = 2'b00; e.addr = m_addr; e.wdata = m_data; e.rdata = '0; e.ram_data = '0;
        return e;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_last_b = 1'b1;
        m_terr   = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        cur_idle = 1'b1;
    endtask

    // Clear: one cycle with mem_clr, one cycle with clr_done; the watchdog flag drops with clr_done.
    task automatic push_clr();
        exp_t e;
        e = base(1'b1);
        e.mem_clr = 1'b1;
        exp_q.push_back(e);
        e.mem_clr = 1'b0;
        e.clr_done = 1'b1;
        e.terr = 1'b0;
        exp_q.push_back(e);
        m_terr = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = '0;
    endtask

    // A granted transfer: issue cycle, then (reads) wait cycles until valid or TO, then the ack cycle.
    task automatic push_txn(input logic is_b, input logic rw, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        exp_t e;
        int   k;
        int   n;
        m_addr   = ad;
        m_data   = wd;
        m_last_b = is_b;
        e = base(1'b1);
        e.grant = is_b ? 2'b10 : 2'b01;
        e.mem_rw = rw;
        exp_q.push_back(e);
        e.mem_rw = 1'b0;
        if (rw) begin
            ram[ad] = wd;
        end else begin
            k = (force_k > 0) ? force_k : int'($urandom_range(1, TO + 2));
            n = (k < TO) ? k : TO;
            for (int i = 1; i <= n; i++) begin
                e.wt = 1'b1;
                e.ram_valid = (i == k);
                e.ram_data = ram[ad];
                exp_q.push_back(e);
            end
            e.wt = 1'b0;
            e.ram_valid = 1'b0;
            e.chk_rd = 1'b1;
            if (k <= TO) begin
                e.rdata = ram[ad];
            end else begin
                e.rdata = '0;
                e.terr = 1'b1;
                m_terr = 1'b1;
            end
        end
        if (is_b) e.b_ack = 1'b1;
        else      e.a_ack = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic decide();
        if (cur_idle) begin
            if (bus.clr_req)
                push_clr();
            else if (bus.a_req && (!bus.b_req || m_last_b))
                push_txn(1'b0, bus.a_rw, bus.a_addr, bus.a_wdata);
            else if (bus.b_req)
                push_txn(1'b1, bus.b_rw, bus.b_addr, bus.b_wdata);
        end
    endtask

    // One clock: predict, advance, compare every output, then drive RAM and requesters for this cycle.
    task automatic step();
        decide();
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            cur_idle = 1'b0;
        end else begin
            cur = base(1'b0);
            cur_idle = 1'b1;
        end
        chk("ctl{grant,busy,a_ack,b_ack,clr_done,mem_rw,mem_clr,terr}",
            64'({bus.grant, bus.busy, bus.a_ack, bus.b_ack, bus.clr_done, bus.mem_rw, bus.mem_clr, bus.timeout_err}),
            64'({cur.grant, cur.busy, cur.a_ack, cur.b_ack, cur.clr_done, cur.mem_rw, cur.mem_clr, cur.terr}));
        chk("mem_address", 64'(bus.mem_address), 64'(cur.addr));
        chk("mem_data_in", 64'(bus.mem_data_in), 64'(cur.wdata));
        if (cur.chk_rd)
            chk("rdata", 64'(cur.a_ack ? bus.a_rdata : bus.b_rdata), 64'(cur.rdata));

        bus.mem_out_valid = cur.ram_valid | (~cur.wt & ($urandom_range(0, 3) == 0));
        bus.mem_data_out  = cur.ram_valid ? cur.ram_data : DW'($urandom);

        if (bus.a_ack) begin
            bus.a_req = 1'b0;
        end else if (bus.a_req && bus.grant == 2'b01) begin
            bus.a_rw = 1'($urandom_range(0, 1)); bus.a_addr = AW'($urandom); bus.a_wdata = DW'($urandom);
        end else if (!bus.a_req && rand_mode && $urandom_range(0, 99) < p_req) begin
            bus.a_req = 1'b1;
            bus.a_rw = 1'($urandom_range(0, 1)); bus.a_addr = AW'($urandom); bus.a_wdata = DW'($urandom);
        end
        if (bus.b_ack) begin
            bus.b_req = 1'b0;
        end else if (bus.b_req && bus.grant == 2'b10) begin
            bus.b_rw = 1'($urandom_range(0, 1)); bus.b_addr = AW'($urandom); bus.b_wdata = DW'($urandom);
        end else if (!bus.b_req && rand_mode && $urandom_range(0, 99) < p_req) begin
            bus.b_req = 1'b1;
            bus.b_rw = 1'($urandom_range(0, 1)); bus.b_addr = AW'($urandom); bus.b_wdata = DW'($urandom);
        end
        if (bus.clr_done)
            bus.clr_req = 1'b0;
        else if (!bus.clr_req && rand_mode && $urandom_range(0, 99) < p_clr)
            bus.clr_req = 1'b1;
    endtask

    // port: 0 = A ack, 1 = B ack, 2 = clr_done; n = cycles from the sampling edge.
    task automatic wait_ack(input string name, input int port, input int bound, output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            n++;
            seen = (port == 0) ? bus.a_ack : (port == 1) ? bus.b_ack : bus.clr_done;
        end
        chk({name, "_seen"}, 64'(seen), 64'(1));
    endtask

    task automatic drain(input string name);
        logic done;
        rand_mode = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (!bus.a_req && !bus.b_req && !bus.clr_req && exp_q.size() == 0 && cur_idle)
                done = 1'b1;
            else
                step();
        end
        chk({name, "_drain"}, 64'(done), 64'(1));
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({bus.a_ack, bus.b_ack, bus.clr_done, bus.mem_rw, bus.mem_clr, bus.grant, bus.busy,
                    bus.timeout_err, bus.mem_address, bus.mem_data_in, bus.a_rdata, bus.b_rdata});
    endfunction

    initial begin
        int n;
        int nacks;
        int t_b, t_c, t_d, t_a;
        logic [3:0] order;
        logic [1:0] first;

        bus.a_req = 1'b0; bus.a_rw = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_rw = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        bus.clr_req = 1'b0; bus.mem_data_out = '0; bus.mem_out_valid = 1'b0;
        rand_mode = 1'b0; p_req = 0; p_clr = 0; force_k = 0;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", all_outputs(), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // A writes 0x5A to address 3.
        bus.a_req = 1'b1; bus.a_rw = 1'b1; bus.a_addr = 4'd3; bus.a_wdata = 8'h5A;
        step();
        chk("wr_issue", 64'({bus.mem_rw, bus.mem_address, bus.mem_data_in, bus.grant, bus.a_ack}),
            64'({1'b1, 4'd3, 8'h5A, 2'b01, 1'b0}));
        step();
        chk("wr_ack", 64'({bus.a_ack, bus.grant, bus.mem_rw}), 64'({1'b1, 2'b01, 1'b0}));
        step();
        chk("wr_idle", 64'({bus.a_ack, bus.grant, bus.busy}), 64'h0);

        // B reads address 3, RAM answers one cycle after issue.
        force_k = 1;
        bus.b_req = 1'b1; bus.b_rw = 1'b0; bus.b_addr = 4'd3;
        wait_ack("rd", 1, 10, n);
        chk("rd_latency", 64'(n), 64'(3));
        chk("rd_data", 64'(bus.b_rdata), 64'h5A);
        chk("rd_terr", 64'(bus.timeout_err), 64'h0);
        step();

        // Both ports requesting continuously: grants alternate starting with A.
        force_k = 0; rand_mode = 1'b1; p_req = 100; p_clr = 0;
        nacks = 0; order = 4'b0000;
        for (int i = 0; i < 80 && nacks < 4; i++) begin
            step();
            if (bus.a_ack) begin order[nacks] = 1'b0; nacks++; end
            else if (bus.b_ack) begin order[nacks] = 1'b1; nacks++; end
        end
        chk("alt_count", 64'(nacks), 64'(4));
        chk("alt_order", 64'(order), 64'(4'b1010));
        drain("alt");

        // Read with no RAM response: timeout after TO wait cycles, zero data, sticky flag.
        force_k = TO + 2;
        bus.a_req = 1'b1; bus.a_rw = 1'b0; bus.a_addr = 4'd5;
        wait_ack("to", 0, 20, n);
        chk("to_latency", 64'(n), 64'(6));
        chk("to_rdata", 64'(bus.a_rdata), 64'h0);
        chk("to_err", 64'(bus.timeout_err), 64'h1);
        force_k = 0;
        bus.b_req = 1'b1; bus.b_rw = 1'b1; bus.b_addr = 4'd7; bus.b_wdata = 8'hC3;
        wait_ack("to_wr", 1, 10, n);
        chk("to_err_sticky", 64'(bus.timeout_err), 64'h1);
        step();

        // Clear raised during B's read wait, with A pending: B, then clear, then A.
        force_k = 3;
        bus.b_req = 1'b1; bus.b_rw = 1'b0; bus.b_addr = 4'd3;
        step();
        step();
        bus.clr_req = 1'b1;
        bus.a_req = 1'b1; bus.a_rw = 1'b1; bus.a_addr = 4'd9; bus.a_wdata = 8'h21;
        t_b = 0; t_c = 0; t_d = 0; t_a = 0;
        for (int s = 3; s <= 14; s++) begin
            step();
            if (bus.b_ack) t_b = s;
            if (bus.mem_clr) t_c = s;
            if (bus.clr_done) t_d = s;
            if (bus.grant == 2'b01 && t_a == 0) t_a = s;
        end
        chk("clr_sequence", 64'({8'(t_b), 8'(t_c), 8'(t_d), 8'(t_a)}), 64'({8'd5, 8'd7, 8'd8, 8'd10}));
        chk("clr_terr", 64'(bus.timeout_err), 64'h0);
        force_k = 0;

        // Asynchronous reset in the middle of a read wait, then A must win the first tie.
        force_k = TO + 2;
        bus.b_req = 1'b1; bus.b_rw = 1'b0; bus.b_addr = 4'd3;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_async", all_outputs(), 64'h0);
        model_reset();
        bus.a_req = 1'b0; bus.b_req = 1'b0; bus.clr_req = 1'b0; bus.mem_out_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        force_k = 0;
        bus.a_req = 1'b1; bus.a_rw = 1'b1; bus.a_addr = 4'd1; bus.a_wdata = 8'h11;
        bus.b_req = 1'b1; bus.b_rw = 1'b1; bus.b_addr = 4'd2; bus.b_wdata = 8'h22;
        first = 2'b00;
        for (int i = 0; i < 10 && first == 2'b00; i++) begin
            step();
            first = {bus.a_ack, bus.b_ack};
        end
        chk("tie_after_reset", 64'(first), 64'(2'b10));
        drain("post_reset");

        // Random traffic from both ports with occasional clears and random RAM latency.
        rand_mode = 1'b1; p_req = 35; p_clr = 3;
        repeat (3000) step();
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
